// File: rtl/udp_tx_pkg.sv
// Shared types and defaults for the UDP transmit payload packetizer.
// The optional flush timer is enabled with the UDP_TX_TIMEOUT_EN macro.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_SEND       = 2'd2,
    ST_GAP        = 2'd3
  } tx_state_e;

  localparam int DEF_DEPTH          = 512;
  localparam int DEF_MAX_LEN        = 256;
  localparam int DEF_IFG_CYCLES     = 12;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Smallest n with 2**n >= value; used for pointer and counter widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/udp_tx_byte_fifo.sv
// Byte FIFO for the transmit packetizer: power-of-two depth, registered read
// data, and a fill count from which the writer derives its ready.
module udp_tx_byte_fifo
  import udp_tx_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          tx_clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_wr     = wr_en && (count_q != FULL_CNT);
    do_rd     = rd_en && (count_q != '0);
    wr_ptr_d  = do_wr ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_rd ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    rd_data_d = do_rd ? mem[rd_ptr_q] : rd_data_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - (AW + 1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage has no reset; only locations behind the write pointer are ever read.
  always_ff @(posedge tx_clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/udp_tx_packetizer.sv
// Transmit payload packetizer: buffers application bytes and emits UDP payloads
// of up to MAX_LEN bytes. Define UDP_TX_TIMEOUT_EN to flush idle partial buffers.
module udp_tx_packetizer
  import udp_tx_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int MAX_LEN        = DEF_MAX_LEN,
  parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  output logic [15:0] tx_data_length,
  output logic        busy,
  output logic        overflow
);

  localparam int              AW        = clog2(DEPTH);
  localparam int              PW        = AW + 1;
  localparam int              GW        = clog2(IFG_CYCLES + 1);
  localparam logic [PW-1:0]   MAX_LEN_P = PW'(MAX_LEN);
  localparam logic [PW-1:0]   DEPTH_P   = PW'(DEPTH);
  localparam logic [GW-1:0]   IFG_LAST  = GW'(IFG_CYCLES - 1);

  tx_state_e     state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] remain_q, remain_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          flush_q, flush_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          wr_accept;
  logic          flush_eff;
  logic          timeout;
  logic          trigger;
  logic [PW-1:0] pending_inc;
  logic [PW-1:0] pkt_len;
  logic          fifo_rd_en;
  logic [7:0]    fifo_rd_data;
  logic [AW:0]   fifo_count;

`ifdef UDP_TX_TIMEOUT_EN
  localparam int            TW        = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_P = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
`endif

  udp_tx_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .tx_clk  (tx_clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  assign wr_ready = (fifo_count != DEPTH_P);

  always_comb begin
    wr_accept   = wr_valid && wr_ready;
    pending_inc = pending_q + (wr_accept ? PW'(1) : PW'(0));
    flush_eff   = flush_q || (wr_accept && wr_last);
    pkt_len     = (pending_inc > MAX_LEN_P) ? MAX_LEN_P : pending_inc;
`ifdef UDP_TX_TIMEOUT_EN
    timeout = (timer_q == TIMEOUT_P) && (pending_q != '0);
    if (wr_accept) begin
      timer_d = '0;
    end else if ((state_q == ST_IDLE) && (pending_q != '0) && (timer_q != TIMEOUT_P)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
`else
    timeout = 1'b0;
`endif
    // A byte accepted this cycle already counts towards the trigger decision.
    trigger = (pending_inc >= MAX_LEN_P) || (flush_eff && (pending_inc != '0)) || timeout;

    state_d    = state_q;
    pending_d  = pending_inc;
    flush_d    = flush_eff;
    len_d      = len_q;
    remain_d   = remain_q;
    gap_d      = gap_q;
    valid_d    = 1'b0;
    fifo_rd_en = 1'b0;
    overflow_d = overflow_q || (wr_valid && !wr_ready);

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d   = ST_WAIT_READY;
          len_d     = pkt_len;
          pending_d = pending_inc - pkt_len;
          flush_d   = (pending_inc == pkt_len) ? 1'b0 : flush_eff;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_READY: begin
        if (tx_ready) begin
          state_d    = ST_SEND;
          fifo_rd_en = 1'b1;
          valid_d    = 1'b1;
          remain_d   = len_q - PW'(1);
        end else begin
          state_d = ST_WAIT_READY;
        end
      end
      ST_SEND: begin
        if (remain_q != '0) begin
          fifo_rd_en = 1'b1;
          valid_d    = 1'b1;
          remain_d   = remain_q - PW'(1);
        end else begin
          state_d = ST_GAP;
          gap_d   = IFG_LAST;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Single state register for the FSM, accounting and registered outputs.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      flush_q    <= 1'b0;
      len_q      <= '0;
      remain_q   <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UDP_TX_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      flush_q    <= flush_d;
      len_q      <= len_d;
      remain_q   <= remain_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UDP_TX_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign tx_data        = fifo_rd_data;
  assign tx_data_valid  = valid_q;
  assign tx_data_length = 16'(len_q);
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Self-checking bench for udp_tx_packetizer: directed scenarios plus random
// messages checked against a message-level chunking and byte-order model.
module tb_udp_tx_packetizer;

  localparam int DEPTH   = 512;
  localparam int MAX_LEN = 256;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 1024;

  logic        tx_clk;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_last;
  logic        wr_ready;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic [15:0] tx_data_length;
  logic        busy;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;

  logic [7:0] exp_bytes [$];
  int         exp_lens  [$];
  logic [7:0] rx_bytes  [$];
  int         pkt_lens  [$];
  int         pkt_runs  [$];
  int         gaps      [$];
  int         len_unstable = 0;
  int         boundary_lens [6] = '{1, 255, 256, 257, 512, 513};

  udp_tx_packetizer #(
    .DEPTH          (DEPTH),
    .MAX_LEN        (MAX_LEN),
    .IFG_CYCLES     (IFG),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .tx_clk         (tx_clk),
    .reset          (reset),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_last        (wr_last),
    .wr_ready       (wr_ready),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_data_length (tx_data_length),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  // Output monitor: collects bytes, per-packet lengths, run lengths and gaps.
  initial begin : monitor
    bit prev_valid;
    int run_len;
    int idle_run;
    bit seen_pkt;
    int start_len;
    prev_valid = 1'b0; run_len = 0; idle_run = 0; seen_pkt = 1'b0; start_len = 0;
    forever begin
      @(negedge tx_clk);
      if (reset) begin
        prev_valid = 1'b0; run_len = 0; idle_run = 0; seen_pkt = 1'b0;
      end else begin
        if (tx_data_valid) begin
          if (!prev_valid) begin
            run_len   = 0;
            start_len = int'(tx_data_length);
            if (seen_pkt) gaps.push_back(idle_run);
          end
          if (int'(tx_data_length) != start_len) len_unstable++;
          rx_bytes.push_back(tx_data);
          run_len++;
        end else begin
          if (prev_valid) begin
            pkt_lens.push_back(start_len);
            pkt_runs.push_back(run_len);
            seen_pkt = 1'b1;
            idle_run = 0;
          end
          idle_run++;
        end
        prev_valid = tx_data_valid;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge tx_clk);
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    while (!wr_ready && waited < 5000) begin
      tick();
      waited++;
    end
    if (!wr_ready) check("wr_ready_wait", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Reference model: a message is cut into MAX_LEN chunks plus a remainder.
  task automatic send_message(input int n, input int max_gap);
    logic [7:0] d;
    int rem;
    rem = n;
    while (rem > MAX_LEN) begin
      exp_lens.push_back(MAX_LEN);
      rem -= MAX_LEN;
    end
    exp_lens.push_back(rem);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      exp_bytes.push_back(d);
      write_byte(d, (i == n - 1));
      idle_cycles($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
      if (rx_bytes.size() >= exp_bytes.size() && !busy && !tx_data_valid) done = 1'b1;
    end
    check("drain_done", done, 1);
    idle_cycles(4);
  endtask

  task automatic check_message(input string tag);
    check({tag, "_pkt_count"}, pkt_lens.size(), exp_lens.size());
    for (int i = 0; i < exp_lens.size() && i < pkt_lens.size(); i++) begin
      check({tag, "_pkt_len"}, pkt_lens[i], exp_lens[i]);
      check({tag, "_pkt_run"}, pkt_runs[i], exp_lens[i]);
    end
    check({tag, "_byte_count"}, rx_bytes.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      check({tag, "_byte"}, rx_bytes[i], exp_bytes[i]);
    end
    for (int i = 0; i < gaps.size(); i++) begin
      n_vec++;
      assert (gaps[i] >= IFG + 2) else begin
        n_err++;
        $error("FAIL %s_ifg: observed %0d idle cycles, expected at least %0d", tag, gaps[i], IFG + 2);
      end
    end
    check({tag, "_len_stable"}, len_unstable, 0);
    exp_bytes.delete(); exp_lens.delete(); rx_bytes.delete();
    pkt_lens.delete(); pkt_runs.delete(); gaps.delete();
    len_unstable = 0;
  endtask

  initial begin : stimulus
    logic [7:0] d;
    int cyc;
    int seen;
    logic [7:0] t1 [4];
    t1 = '{8'hAB, 8'hCD, 8'hEF, 8'h01};

    reset = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge tx_clk);
    reset = 1'b0;
    @(negedge tx_clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_length", tx_data_length, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_ready", wr_ready, 1);

    // Four-byte message with tx_ready held high.
    tx_ready = 1'b1;
    exp_lens.push_back(4);
    for (int i = 0; i < 4; i++) begin
      exp_bytes.push_back(t1[i]);
      write_byte(t1[i], (i == 3));
    end
    wait_drain(500);
    check_message("t4");

    // 600-byte message splits into 256, 256 and 88.
    send_message(600, 0);
    wait_drain(3000);
    check_message("t600");

    // Stall in WAIT_READY, then release.
    tx_ready = 1'b0;
    send_message(10, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge tx_clk);
      check("hold_valid", tx_data_valid, 0);
      check("hold_busy", busy, 1);
    end
    tx_ready = 1'b1;
    @(negedge tx_clk);
    check("start_valid", tx_data_valid, 1);
    check("start_byte", tx_data, exp_bytes[0]);
    check("start_len", tx_data_length, 10);
    wait_drain(500);
    check_message("hold");

    // Fill the buffer completely, then push one extra byte.
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      exp_bytes.push_back(d);
      write_byte(d, 1'b0);
    end
    exp_lens.push_back(MAX_LEN);
    exp_lens.push_back(MAX_LEN);
    check("full_wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 8'hEE; wr_last = 1'b0;
    @(negedge tx_clk);
    wr_valid = 1'b0;
    check("overflow_set", overflow, 1);
    check("full_wr_ready_after", wr_ready, 0);
    tx_ready = 1'b1;
    wait_drain(3000);
    check_message("ovf");
    check("overflow_sticky", overflow, 1);

    // Boundary lengths, then random lengths, with random tx_ready.
    rand_ready = 1'b1;
    for (int m = 0; m < 6; m++) begin
      send_message(boundary_lens[m], 2);
      wait_drain(20000);
      check_message("bnd");
    end
    for (int m = 0; m < 5; m++) begin
      send_message($urandom_range(1, 700), 2);
      wait_drain(20000);
      check_message("rnd");
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;

    // Partial buffer without wr_last.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      exp_bytes.push_back(d);
      write_byte(d, 1'b0);
    end
`ifdef UDP_TX_TIMEOUT_EN
    exp_lens.push_back(3);
    cyc = 0;
    while (!tx_data_valid && cyc < 1500) begin
      @(negedge tx_clk);
      cyc++;
    end
    n_vec++;
    assert (cyc >= 1022 && cyc <= 1030) else begin
      n_err++;
      $error("FAIL timeout_latency: observed %0d cycles, expected about 1026", cyc);
    end
    wait_drain(500);
    check_message("tmo");
`else
    seen = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge tx_clk);
      if (tx_data_valid || busy) seen++;
    end
    check("no_timeout_pkt", seen, 0);
    d = 8'($urandom);
    exp_bytes.push_back(d);
    write_byte(d, 1'b1);
    exp_lens.push_back(4);
    wait_drain(500);
    check_message("notmo");
`endif

    // Reset in the middle of a 10-byte packet.
    for (int i = 0; i < 10; i++) write_byte(8'(i + 1), (i == 9));
    cyc = 0;
    while (!tx_data_valid && cyc < 100) begin
      @(negedge tx_clk);
      cyc++;
    end
    check("rst_pkt_started", tx_data_valid, 1);
    repeat (4) @(negedge tx_clk);
    check("rst_mid_valid", tx_data_valid, 1);
    check("rst_mid_byte", tx_data, 8'd5);
    check("rst_mid_overflow", overflow, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", tx_data_valid, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_length", tx_data_length, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    check("arst_wr_ready", wr_ready, 1);
    repeat (3) @(negedge tx_clk);
    reset = 1'b0;
    #1;
    exp_bytes.delete(); exp_lens.delete(); rx_bytes.delete();
    pkt_lens.delete(); pkt_runs.delete(); gaps.delete();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge tx_clk);
      if (tx_data_valid || busy) seen++;
    end
    check("no_residual", seen, 0);
    check("no_residual_bytes", rx_bytes.size(), 0);
    check("post_rst_overflow", overflow, 0);
    check("post_rst_wr_ready", wr_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
